loop_over_all_nibbles: RTL and testbench

//  Nibble-serial 32-bit ALU: processes one 4-bit nibble of word1/word2 per clock, LSB first.

---
 rtl/loop_over_all_nibbles.sv | 64 ++++++
 tb/tb_loop_over_all_nibbles.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/loop_over_all_nibbles.sv
// loop_over_all_nibbles: nibble-serial 32-bit ALU, one nibble per clock LSB first, with early
// termination for short adds and an all-0xF compare flag for XNOR equality checks.
module loop_over_all_nibbles (
    input  logic        clk,
    input  logic        rst,
    input  logic        loop_perm_to_count,
    input  logic [4:0]  ctrl,
    input  logic [2:0]  loop_nibbles_number,
    input  logic        word2_is_signed_and_negative,
    input  logic        check_if_result_0xF,
    input  logic [31:0] word1,
    input  logic [31:0] word2,
    input  logic [31:0] preinit_result,
    output logic [31:0] result,
    output logic        busy,
    output logic        carry_in_out
);
    localparam logic [4:0] ADD  = 5'b00001;
    localparam logic [4:0] AND  = 5'b00010;
    localparam logic [4:0] OR   = 5'b00100;
    localparam logic [4:0] XOR  = 5'b01000;
    localparam logic [4:0] XNOR = 5'b10000;

    logic [2:0] idx;
    logic       carry, flag, is_add, last;
    logic [3:0] a, b, nib;
    logic [4:0] sum;

    always_comb begin
        a      = word1[{idx, 2'b00} +: 4];
        b      = (idx <= loop_nibbles_number) ? word2[{idx, 2'b00} +: 4] : {4{word2_is_signed_and_negative}};
        sum    = {1'b0, a} + {1'b0, b} + {4'b0, carry};
        is_add = ctrl == ADD;
        nib    = is_add        ? sum[3:0] :
                 ctrl == AND   ? a & b :
                 ctrl == OR    ? a | b :
                 ctrl == XOR   ? a ^ b :
                 ctrl == XNOR  ? ~(a ^ b) : 4'h0;
        // an add may stop once the carry matches the sign extension: upper nibbles are unchanged
        last   = idx == 3'd7 || (idx >= loop_nibbles_number && !check_if_result_0xF &&
                 (!is_add || sum[4] == word2_is_signed_and_negative));
        busy   = loop_perm_to_count && !rst && !last;
        carry_in_out = check_if_result_0xF ? flag : carry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= 32'h0;
            idx    <= 3'd0;
            carry  <= 1'b0;
            flag   <= 1'b1;
        end else if (!loop_perm_to_count) begin
            result <= preinit_result;
            idx    <= 3'd0;
            carry  <= 1'b0;
            flag   <= 1'b1;
        end else begin
            result[{idx, 2'b00} +: 4] <= nib;
            carry <= is_add & sum[4];
            flag  <= check_if_result_0xF ? flag & (nib == 4'hF) : flag;
            idx   <= last ? 3'd0 : idx + 3'd1;
        end
    end
endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// tb_loop_over_all_nibbles: table vectors, hand sequences and random ops against a
// word-level reference model of the nibble-serial ALU.
module tb_loop_over_all_nibbles;
    localparam logic [4:0] ADD  = 5'b00001;
    localparam logic [4:0] AND  = 5'b00010;
    localparam logic [4:0] OR   = 5'b00100;
    localparam logic [4:0] XOR  = 5'b01000;
    localparam logic [4:0] XNOR = 5'b10000;

    logic        clk = 0, rst = 1, perm = 0, sgn = 0, cmp = 0;
    logic [4:0]  ctrl = ADD;
    logic [2:0]  n = 0;
    logic [31:0] word1 = 0, word2 = 0, pre = 0, result;
    logic        busy, carry_in_out;
    int          errors = 0, checks = 0;

    loop_over_all_nibbles dut (
        .clk(clk), .rst(rst), .loop_perm_to_count(perm), .ctrl(ctrl),
        .loop_nibbles_number(n), .word2_is_signed_and_negative(sgn),
        .check_if_result_0xF(cmp), .word1(word1), .word2(word2),
        .preinit_result(pre), .result(result), .busy(busy), .carry_in_out(carry_in_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [2:0]  n;
        logic        sgn, cmp;
        logic [31:0] w1, w2, pre, exp_r;
        int          exp_cyc;
        logic        exp_c;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Word-level model: whole-word arithmetic, termination found from prefix-sum carries.
    function automatic void model(input logic [4:0] op, input logic [2:0] nn, input logic s,
                                  input logic c, input logic [31:0] w1, input logic [31:0] w2,
                                  input logic [31:0] p, output logic [31:0] r, output int cyc,
                                  output logic co);
        logic [63:0] m, ml, w2e, v;
        int last;
        m   = (64'd1 << (4 * (nn + 1))) - 1;
        w2e = ({32'h0, w2} & m) | (s ? (~m & 64'hFFFF_FFFF) : 64'h0);
        if (op == ADD && !c) begin
            last = 7;
            co   = 0;
            for (int i = nn; i < 8; i++) begin
                ml = (64'd1 << (4 * (i + 1))) - 1;
                co = (((w1 & ml) + (w2e & ml)) >> (4 * (i + 1))) & 1;
                if (co == s || i == 7) begin last = i; break; end
            end
            v = w1 + w2e;
        end else begin
            last = c ? 7 : nn;
            v = op == AND ? w1 & w2e : op == OR ? w1 | w2e : op == XOR ? w1 ^ w2e : ~(w1 ^ w2e);
            v = v & 64'hFFFF_FFFF;
            co = c ? (v == 64'hFFFF_FFFF) : 1'b0;
        end
        ml  = (64'd1 << (4 * (last + 1))) - 1;
        r   = 32'((v & ml) | ({32'h0, p} & ~ml));
        cyc = last + 1;
    endfunction

    task automatic run_op(input string name, input vec_t t);
        int cyc = 0;
        ctrl = t.op; n = t.n; sgn = t.sgn; cmp = t.cmp;
        word1 = t.w1; word2 = t.w2; pre = t.pre; perm = 0;
        @(posedge clk); #1;
        perm = 1;
        forever begin
            @(negedge clk);
            cyc++;
            if (!busy || cyc > 20) break;
        end
        @(posedge clk); #1;
        perm = 0;
        check({name, " cycles"}, cyc, t.exp_cyc);
        check({name, " result"}, result, t.exp_r);
        check({name, " carry"}, {31'h0, carry_in_out}, {31'h0, t.exp_c});
    endtask

    vec_t tab[7];
    vec_t v;

    initial begin
        tab[0] = '{ADD,  0, 0, 0, 32'hFF,       32'h4,        32'hFF,       32'h103,      3, 0};
        tab[1] = '{ADD,  2, 1, 0, 32'h0,        32'h800,      32'h0,        32'hFFFFF800, 8, 0};
        tab[2] = '{ADD,  2, 0, 0, 32'd123,      32'd2,        32'h0,        32'd125,      3, 0};
        tab[3] = '{XNOR, 7, 0, 1, 32'h5,        32'h5,        32'h0,        32'hFFFFFFFF, 8, 1};
        tab[4] = '{XNOR, 7, 0, 1, 32'h5,        32'h6,        32'h0,        32'hFFFFFFFC, 8, 0};
        tab[5] = '{AND,  3, 0, 0, 32'h12345678, 32'h0F0F0F0F, 32'hAAAAAAAA, 32'hAAAA0608, 4, 0};
        tab[6] = '{OR,   0, 1, 0, 32'h10,       32'h1,        32'h55,       32'h51,       1, 0};

        #1;
        check("reset result", result, 0);
        check("reset busy", {31'h0, busy}, 0);
        check("reset carry", {31'h0, carry_in_out}, 0);
        @(posedge clk); #1 rst = 0;

        for (int i = 0; i < 7; i++) run_op($sformatf("vec%0d", i), tab[i]);

        pre = 32'hDEADBEEF; perm = 0;
        @(posedge clk); #1;
        check("idle preload", result, 32'hDEADBEEF);
        check("idle busy", {31'h0, busy}, 0);

        // perm held high after completion must restart from nibble 0
        ctrl = ADD; n = 2; sgn = 0; cmp = 0; word1 = 123; word2 = 2; pre = 0;
        @(posedge clk); #1 perm = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("restart result", result, 125);
        check("restart busy", {31'h0, busy}, 1);
        @(posedge clk); #1 perm = 0;

        // reset mid-operation
        ctrl = ADD; n = 2; sgn = 1; word1 = 0; word2 = 32'h800; pre = 32'h1234;
        @(posedge clk); #1 perm = 1;
        repeat (2) @(posedge clk);
        #2 rst = 1;
        #1;
        check("midrst result", result, 0);
        check("midrst busy", {31'h0, busy}, 0);
        @(posedge clk); #1 rst = 0; perm = 0;
        run_op("after rst", tab[2]);

        for (int k = 0; k < 40; k++) begin
            v.op  = 5'b1 << $urandom_range(0, 4);
            v.n   = 3'($urandom_range(0, 7));
            v.sgn = 1'($urandom);
            v.cmp = (v.op != ADD) && ($urandom_range(0, 2) == 0);
            v.w1  = $urandom;
            v.w2  = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 20);
            v.pre = $urandom_range(0, 1) ? v.w1 : $urandom;
            model(v.op, v.n, v.sgn, v.cmp, v.w1, v.w2, v.pre, v.exp_r, v.exp_cyc, v.exp_c);
            run_op($sformatf("rnd%0d", k), v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
